// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, queue entry type and valid-run helper for the fetch front end
package fetch_pkg;
    localparam int FETCH_WIDTH = 4;
    localparam int DEC_WIDTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    function automatic logic [2:0] lead_valid_count(input logic [3:0] v);
        return !v[0] ? 3'd0 : !v[1] ? 3'd1 : !v[2] ? 3'd2 : !v[3] ? 3'd3 : 3'd4;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer, up to 4 pushes and 4 pops per cycle, sync flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [2:0]                push_n,
    input  entry_t [3:0]              push_e,
    input  logic [2:0]                pop_n,
    output logic [$clog2(QDEPTH):0]   count,
    output entry_t [3:0]              head_e
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    entry_t mem [QDEPTH];
    logic [AW-1:0] head, tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++)
                if (3'(i) < push_n) mem[tail + AW'(i)] <= push_e[i];
            tail <= tail + AW'(push_n);
            head <= head + AW'(pop_n);
            count <= count - CW'(pop_n) + CW'(push_n);
        end
    end

    for (genvar g = 0; g < DEC_WIDTH; g++) begin : g_head
        assign head_e[g] = mem[head + AW'(g)];
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer feeding a 4-wide instruction queue with redirect flush
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_data1,
    input  logic [31:0]             imem_data2,
    input  logic [31:0]             imem_data3,
    input  logic [31:0]             imem_data4,
    input  logic                    imem_valid1,
    input  logic                    imem_valid2,
    input  logic                    imem_valid3,
    input  logic                    imem_valid4,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    input  logic [2:0]              dec_take,
    output logic [2:0]              out_count,
    output logic [31:0]             out_instr0,
    output logic [31:0]             out_instr1,
    output logic [31:0]             out_instr2,
    output logic [31:0]             out_instr3,
    output logic [31:0]             out_pc0,
    output logic [31:0]             out_pc1,
    output logic [31:0]             out_pc2,
    output logic [31:0]             out_pc3,
    output logic [$clog2(QDEPTH):0] q_count
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0] fetch_pc;
    logic fire;
    logic [2:0] k, take;
    entry_t [3:0] push_e, head_e;

    assign imem_addr = fetch_pc;
    // Room is judged on the registered count only; same-cycle pops are not credited.
    assign fire = (CW'(QDEPTH) - q_count) >= CW'(FETCH_WIDTH);
    assign k = fire ? lead_valid_count({imem_valid4, imem_valid3, imem_valid2, imem_valid1}) : 3'd0;
    assign out_count = q_count >= CW'(DEC_WIDTH) ? 3'(DEC_WIDTH) : q_count[2:0];
    assign take = dec_take > out_count ? out_count : dec_take;

    assign push_e[0] = '{instr: imem_data1, pc: fetch_pc};
    assign push_e[1] = '{instr: imem_data2, pc: fetch_pc + 32'd4};
    assign push_e[2] = '{instr: imem_data3, pc: fetch_pc + 32'd8};
    assign push_e[3] = '{instr: imem_data4, pc: fetch_pc + 32'd12};

    always_ff @(posedge clk) begin
        if (rst) fetch_pc <= RESET_PC;
        else if (redirect) fetch_pc <= redirect_pc & ~32'd3;
        else fetch_pc <= fetch_pc + {27'd0, k, 2'b00};
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk(clk),
        .rst(rst),
        .flush(redirect),
        .push_n(k),
        .push_e(push_e),
        .pop_n(take),
        .count(q_count),
        .head_e(head_e)
    );

    assign out_instr0 = head_e[0].instr;
    assign out_instr1 = head_e[1].instr;
    assign out_instr2 = head_e[2].instr;
    assign out_instr3 = head_e[3].instr;
    assign out_pc0 = head_e[0].pc;
    assign out_pc1 = head_e[1].pc;
    assign out_pc2 = head_e[2].pc;
    assign out_pc3 = head_e[3].pc;

    assert property (@(posedge clk) disable iff (rst) dec_take <= out_count);
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with an inverted-address memory model
module tb_fetch_ctrl;
    logic clk = 0;
    logic rst;
    logic [31:0] imem_addr;
    logic [31:0] d1, d2, d3, d4;
    logic [3:0] v;
    logic redirect;
    logic [31:0] redirect_pc;
    logic [2:0] dec_take;
    logic [2:0] out_count;
    logic [31:0] oi0, oi1, oi2, oi3, op0, op1, op2, op3;
    logic [3:0] q_count;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    // Memory returns the bitwise inverse of each word's address.
    assign d1 = ~imem_addr;
    assign d2 = ~(imem_addr + 32'd4);
    assign d3 = ~(imem_addr + 32'd8);
    assign d4 = ~(imem_addr + 32'd12);

    fetch_ctrl #(.QDEPTH(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr),
        .imem_data1(d1), .imem_data2(d2), .imem_data3(d3), .imem_data4(d4),
        .imem_valid1(v[0]), .imem_valid2(v[1]), .imem_valid3(v[2]), .imem_valid4(v[3]),
        .redirect(redirect), .redirect_pc(redirect_pc), .dec_take(dec_take),
        .out_count(out_count),
        .out_instr0(oi0), .out_instr1(oi1), .out_instr2(oi2), .out_instr3(oi3),
        .out_pc0(op0), .out_pc1(op1), .out_pc2(op2), .out_pc3(op3),
        .q_count(q_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; v = 4'b0000; redirect = 0; redirect_pc = 0; dec_take = 0;
        tick();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_q", 32'(q_count), 32'd0);
        chk("rst_oc", 32'(out_count), 32'd0);
        chk("rst_instr0", oi0, 32'h0);
        chk("rst_pc3", op3, 32'h0);

        rst = 0; v = 4'b1111;
        tick();
        chk("run1_addr", imem_addr, 32'd16);
        chk("run1_q", 32'(q_count), 32'd4);
        chk("run1_oc", 32'(out_count), 32'd4);
        chk("run1_pc0", op0, 32'd0);
        chk("run1_pc1", op1, 32'd4);
        chk("run1_pc2", op2, 32'd8);
        chk("run1_pc3", op3, 32'd12);
        chk("run1_instr0", oi0, ~32'd0);
        chk("run1_instr3", oi3, ~32'd12);
        tick();
        chk("run2_addr", imem_addr, 32'd32);
        chk("run2_q", 32'(q_count), 32'd8);
        tick();
        chk("full_hold_addr", imem_addr, 32'd32);
        chk("full_hold_q", 32'(q_count), 32'd8);

        redirect = 1; redirect_pc = 32'h40;
        tick();
        chk("redir40_q", 32'(q_count), 32'd0);
        chk("redir40_oc", 32'(out_count), 32'd0);
        chk("redir40_addr", imem_addr, 32'h40);

        redirect = 0; v = 4'b1011;
        tick();
        chk("partial_q", 32'(q_count), 32'd2);
        chk("partial_addr", imem_addr, 32'h48);
        chk("partial_oc", 32'(out_count), 32'd2);
        chk("partial_pc1", op1, 32'h44);
        chk("partial_instr1", oi1, ~32'h44);

        v = 4'b0000;
        tick();
        chk("k0_q", 32'(q_count), 32'd2);
        chk("k0_addr", imem_addr, 32'h48);

        v = 4'b0111;
        tick();
        chk("k3_q", 32'(q_count), 32'd5);
        chk("k3_addr", imem_addr, 32'h54);

        v = 4'b1111; dec_take = 1;
        tick();
        chk("bound_q", 32'(q_count), 32'd4);
        chk("bound_addr", imem_addr, 32'h54);
        chk("bound_pc0", op0, 32'h44);

        dec_take = 0;
        tick();
        chk("bound_fire_q", 32'(q_count), 32'd8);
        chk("bound_fire_addr", imem_addr, 32'h64);
        chk("bound_fire_pc3", op3, 32'h50);

        dec_take = 2;
        tick();
        chk("pop2_q", 32'(q_count), 32'd6);
        chk("pop2_pc0", op0, 32'h4C);

        dec_take = 2; redirect = 1; redirect_pc = 32'h1003;
        tick();
        chk("redir_pp_q", 32'(q_count), 32'd0);
        chk("redir_pp_oc", 32'(out_count), 32'd0);
        chk("redir_pp_addr", imem_addr, 32'h1000);

        redirect = 0; dec_take = 0;
        tick();
        chk("redir_pp_pc0", op0, 32'h1000);
        chk("redir_pp_instr0", oi0, ~32'h1000);
        chk("redir_pp_q2", 32'(q_count), 32'd4);

        exp_pc = 32'h1000;
        for (int i = 0; i < 10; i++) begin
            chk("drain_oc", 32'(out_count), 32'd4);
            chk("drain_pc0", op0, exp_pc);
            chk("drain_pc3", op3, exp_pc + 32'd12);
            chk("drain_instr2", oi2, ~(exp_pc + 32'd8));
            dec_take = out_count;
            exp_pc = exp_pc + 32'd16;
            tick();
        end
        dec_take = 0;
        chk("drain_end_q", 32'(q_count), 32'd4);
        chk("drain_end_addr", imem_addr, exp_pc + 32'd16);

        redirect = 1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFF8);
        redirect = 0;
        tick();
        chk("wrap_q", 32'(q_count), 32'd4);
        chk("wrap_pc0", op0, 32'hFFFF_FFF8);
        chk("wrap_pc1", op1, 32'hFFFF_FFFC);
        chk("wrap_pc2", op2, 32'h0);
        chk("wrap_pc3", op3, 32'h4);
        chk("wrap_addr", imem_addr, 32'h8);

        rst = 1; redirect = 1; redirect_pc = 32'h2000; dec_take = 2;
        tick();
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_q", 32'(q_count), 32'd0);
        chk("midrst_oc", 32'(out_count), 32'd0);
        chk("midrst_pc0", op0, 32'h0);
        rst = 0; redirect = 0; dec_take = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
